// File: rtl/idx_free_list.sv
// ---------------------------------------------------------------------------
// idx_free_list: FIFO pool of free indices with allocation map and double-free
// detection. Rev 1.0 -- initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module idx_free_list #(
  parameter int DEPTH = 32,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            alloc_vld,
  input  logic            alloc_rdy,
  output logic [IDXW-1:0] alloc_idx,
  input  logic            rel_vld,
  output logic            rel_rdy,
  input  logic [IDXW-1:0] rel_idx,
  output logic [IDXW:0]   free_count,
  output logic            init_done,
  output logic            err_dbl_free
);

  localparam logic [IDXW:0] INIT_LAST = (IDXW+1)'(DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   rd_ptr_q;
  logic [IDXW-1:0]   wr_ptr_q;
  logic [IDXW:0]     cnt_q;
  logic [IDXW:0]     cnt_d;
  logic [DEPTH-1:0]  map_q;
  logic [DEPTH-1:0]  map_d;
  logic              err_q;
  logic [IDXW-1:0]   fifo_q [DEPTH];

  logic              run;
  logic              alloc_fire;
  logic              rel_fire;
  logic              rel_legal;
  logic              rel_bad;
  logic              wr_en;
  logic [IDXW-1:0]   wr_data;

  assign run        = (state_q == S_RUN);
  assign alloc_vld  = run && (cnt_q != '0);
  assign alloc_idx  = alloc_vld ? fifo_q[rd_ptr_q] : '0;
  assign rel_rdy    = run;
  assign free_count = cnt_q;
  assign init_done  = run;
  assign err_dbl_free = err_q;

  assign alloc_fire = alloc_vld & alloc_rdy;
  assign rel_fire   = rel_vld & run;
  // Map is sampled pre-edge, so releasing the index allocated this cycle is a double free.
  assign rel_legal  = rel_fire & map_q[rel_idx];
  assign rel_bad    = rel_fire & ~map_q[rel_idx];

  // INIT seeds slot k with value k, using the write pointer as the counter.
  assign wr_en   = ~run | rel_legal;
  assign wr_data = run ? rel_idx : wr_ptr_q;

  always_comb begin
    map_d = map_q;
    if (rel_legal)  map_d[rel_idx]   = 1'b0;
    if (alloc_fire) map_d[alloc_idx] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, alloc_fire})
      2'b10:   cnt_d = cnt_q + (IDXW+1)'(1);
      2'b01:   cnt_d = cnt_q - (IDXW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      map_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_INIT && cnt_q == INIT_LAST) state_q <= S_RUN;
      if (alloc_fire) rd_ptr_q <= rd_ptr_q + IDXW'(1);
      if (wr_en)      wr_ptr_q <= wr_ptr_q + IDXW'(1);
      cnt_q <= cnt_d;
      map_q <= map_d;
      err_q <= rel_bad;
    end
  end

  // Storage is fully rewritten by INIT, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_idx_free_list.sv
// ---------------------------------------------------------------------------
// tb_idx_free_list: directed, table-driven bench for idx_free_list (DEPTH=32).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_idx_free_list;

  logic       clk;
  logic       resetn;
  logic       alloc_vld;
  logic       alloc_rdy;
  logic [4:0] alloc_idx;
  logic       rel_vld;
  logic       rel_rdy;
  logic [4:0] rel_idx;
  logic [5:0] free_count;
  logic       init_done;
  logic       err_dbl_free;

  int n_cmp = 0;
  int n_bad = 0;

  idx_free_list #(.DEPTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .alloc_vld    (alloc_vld),
    .alloc_rdy    (alloc_rdy),
    .alloc_idx    (alloc_idx),
    .rel_vld      (rel_vld),
    .rel_rdy      (rel_rdy),
    .rel_idx      (rel_idx),
    .free_count   (free_count),
    .init_done    (init_done),
    .err_dbl_free (err_dbl_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    string name;
    int    a_rdy;
    int    r_vld;
    int    r_idx;
    int    e_vld;
    int    e_idx;
    int    e_cnt;
    int    e_err;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    int n;
    n = 0;
    alloc_rdy = 1'b0;
    rel_vld   = 1'b0;
    rel_idx   = '0;
    resetn    = 1'b0;
    step();
    resetn = 1'b1;
    while (!init_done && n < 100) begin
      step();
      n++;
    end
    chk("init_cycles", n, 32);
    chk("init_count", int'(free_count), 32);
    chk("init_alloc_vld", int'(alloc_vld), 1);
    chk("init_alloc_idx", int'(alloc_idx), 0);
  endtask

  initial begin
    int prev;
    tbl[0]  = '{"alloc0",      1, 0, 0,  1, 1, 31, 0};
    tbl[1]  = '{"rel0",        0, 1, 0,  1, 1, 32, 0};
    tbl[2]  = '{"rel0_dbl",    0, 1, 0,  1, 1, 32, 1};
    tbl[3]  = '{"idle_a",      0, 0, 0,  1, 1, 32, 0};
    tbl[4]  = '{"alloc1",      1, 0, 0,  1, 2, 31, 0};
    tbl[5]  = '{"alloc2",      1, 0, 0,  1, 3, 30, 0};
    tbl[6]  = '{"alloc3_rel1", 1, 1, 1,  1, 4, 30, 0};
    tbl[7]  = '{"alloc4_rel4", 1, 1, 4,  1, 5, 29, 1};
    tbl[8]  = '{"rel4",        0, 1, 4,  1, 5, 30, 0};
    tbl[9]  = '{"rel3",        0, 1, 3,  1, 5, 31, 0};
    tbl[10] = '{"rel2",        0, 1, 2,  1, 5, 32, 0};
    tbl[11] = '{"rel17_free",  0, 1, 17, 1, 5, 32, 1};
    tbl[12] = '{"idle_b",      0, 0, 0,  1, 5, 32, 0};

    // Reset values, then a reset landing at INIT cycle 17.
    resetn = 1'b0; alloc_rdy = 1'b0; rel_vld = 1'b0; rel_idx = '0;
    step(); step();
    chk("rst_alloc_vld", int'(alloc_vld), 0);
    chk("rst_alloc_idx", int'(alloc_idx), 0);
    chk("rst_count", int'(free_count), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_err", int'(err_dbl_free), 0);
    chk("rst_rel_rdy", int'(rel_rdy), 0);
    resetn = 1'b1;
    rel_vld = 1'b1; rel_idx = 5'd3;
    for (int i = 0; i < 17; i++) step();
    chk("init17_count", int'(free_count), 17);
    chk("init17_done", int'(init_done), 0);
    chk("init17_alloc_vld", int'(alloc_vld), 0);
    chk("init17_rel_rdy", int'(rel_rdy), 0);
    chk("init17_err", int'(err_dbl_free), 0);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_count", int'(free_count), 0);
    chk("midrst_alloc_vld", int'(alloc_vld), 0);
    chk("midrst_rel_rdy", int'(rel_rdy), 0);
    do_init();

    // Drain the pool in order.
    alloc_rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_vld", int'(alloc_vld), 1);
      chk("drain_idx", int'(alloc_idx), i);
      step();
    end
    chk("drain_end_vld", int'(alloc_vld), 0);
    chk("drain_end_count", int'(free_count), 0);
    step();
    chk("drain_hold_count", int'(free_count), 0);
    chk("drain_hold_vld", int'(alloc_vld), 0);

    // Releases into an empty pool must not bypass.
    alloc_rdy = 1'b0;
    rel_vld = 1'b1; rel_idx = 5'd5;
    chk("empty_rel_nobypass", int'(alloc_vld), 0);
    step();
    chk("rel5_vld", int'(alloc_vld), 1);
    chk("rel5_idx", int'(alloc_idx), 5);
    chk("rel5_count", int'(free_count), 1);
    rel_idx = 5'd9;
    step();
    chk("rel9_idx", int'(alloc_idx), 5);
    chk("rel9_count", int'(free_count), 2);
    rel_vld = 1'b0; alloc_rdy = 1'b1;
    step();
    chk("regrant9_idx", int'(alloc_idx), 9);
    chk("regrant9_count", int'(free_count), 1);
    step();
    chk("regrant_end_vld", int'(alloc_vld), 0);
    chk("regrant_end_count", int'(free_count), 0);

    // Table-driven vectors from a fresh pool.
    do_init();
    for (int i = 0; i < 13; i++) begin
      alloc_rdy = tbl[i].a_rdy[0];
      rel_vld   = tbl[i].r_vld[0];
      rel_idx   = tbl[i].r_idx[4:0];
      step();
      chk({tbl[i].name, "_vld"}, int'(alloc_vld), tbl[i].e_vld);
      chk({tbl[i].name, "_idx"}, int'(alloc_idx), tbl[i].e_idx);
      chk({tbl[i].name, "_cnt"}, int'(free_count), tbl[i].e_cnt);
      chk({tbl[i].name, "_err"}, int'(err_dbl_free), tbl[i].e_err);
    end

    // Bring count to 10, then steady-state alloc + legal release.
    rel_vld = 1'b0; alloc_rdy = 1'b1;
    prev = 0;
    for (int i = 0; i < 22; i++) begin
      prev = int'(alloc_idx);
      step();
    end
    chk("pre_steady_count", int'(free_count), 10);
    chk("pre_steady_idx", int'(alloc_idx), 27);
    chk("pre_steady_last", prev, 26);
    rel_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rel_idx = prev[4:0];
      prev = int'(alloc_idx);
      step();
      chk("steady_count", int'(free_count), 10);
      chk("steady_err", int'(err_dbl_free), 0);
    end
    rel_vld = 1'b0; alloc_rdy = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
